// File: rtl/reg_ram_scanner.sv
// Register-RAM shadow engine: sweeps a block of host register RAM into a staging set and
// commits the whole set to regs_q in one cycle; status slots are written back into the RAM.
module reg_ram_scanner #(
    parameter int                    NUM_REGS  = 10,
    parameter int                    ADDR_W    = 8,
    parameter int                    BASE_ADDR = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
    parameter logic [NUM_REGS*32-1:0] INIT     = '0
) (
    input  logic                     c,
    input  logic                     rst_n,
    input  logic                     ram_gnt,
    output logic [ADDR_W-1:0]        reg_ram_addr,
    output logic                     reg_ram_wr,
    output logic [31:0]              reg_ram_d,
    input  logic [31:0]              reg_ram_q,
    input  logic [NUM_REGS*32-1:0]   status_d,
    output logic [31:0]              flags,
    output logic [NUM_REGS*32-1:0]   regs_q,
    output logic                     commit,
    output logic [NUM_REGS-1:0]      changed
);

    localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FLAG_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] REG0_ADDR = ADDR_W'(BASE_ADDR + 1);

    generate
        if (NUM_REGS < 1 || longint'(BASE_ADDR + NUM_REGS) >= (longint'(1) << ADDR_W)) begin : g_bad_range
            $error("reg_ram_scanner: register block does not fit in the RAM address space");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FLAG,
        S_CHK,
        S_SCAN,
        S_DRAIN,
        S_COMMIT
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    issued_v_q;
    logic [IDX_W-1:0]        issued_idx_q;
    logic                    issued_ro_q;
    logic [31:0]             issued_wdat_q;
    logic [NUM_REGS*32-1:0]  staging_q;
    logic                    scan_ro;

    // Address/write strobes decode only registered state, so they stay put while the grant is low.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        scan_ro      = RO_MASK[idx_q];
        reg_ram_addr = FLAG_ADDR;
        reg_ram_wr   = 1'b0;
        reg_ram_d    = '0;
        case (state_q)
            S_SCAN: begin
                reg_ram_addr = REG0_ADDR + ADDR_W'(idx_q);
                reg_ram_wr   = scan_ro;
                reg_ram_d    = scan_ro ? status_d[idx_q*32 +: 32] : 32'd0;
            end
            S_DRAIN, S_COMMIT: reg_ram_addr = REG0_ADDR + ADDR_W'(idx_q);
            default: reg_ram_addr = FLAG_ADDR;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: staging is a register bank, not a RAM, so it takes the INIT value on reset like regs_q.
            state_q       <= S_FLAG;
            idx_q         <= '0;
            issued_v_q    <= 1'b0;
            issued_idx_q  <= '0;
            issued_ro_q   <= 1'b0;
            issued_wdat_q <= '0;
            staging_q     <= INIT;
            flags         <= '0;
            regs_q        <= INIT;
            changed       <= '0;
            commit        <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignment so every read below sees pre-edge values.
            commit     <= 1'b0;
            issued_v_q <= 1'b0;

            // Status slots take the value we wrote, never the RAM's read-during-write result.
            if (issued_v_q) begin
                staging_q[issued_idx_q*32 +: 32] <= issued_ro_q ? issued_wdat_q : reg_ram_q;
            end

            case (state_q)
                S_FLAG: begin
                    if (ram_gnt) state_q <= S_CHK;
                end
                S_CHK: begin
                    flags <= reg_ram_q;
                    if (reg_ram_q[0]) begin
                        idx_q   <= '0;
                        state_q <= S_SCAN;
                    end else begin
                        state_q <= S_FLAG;
                    end
                end
                S_SCAN: begin
                    if (ram_gnt) begin
                        issued_v_q    <= 1'b1;
                        issued_idx_q  <= idx_q;
                        issued_ro_q   <= scan_ro;
                        issued_wdat_q <= reg_ram_d;
                        if (idx_q == LAST_IDX) state_q <= S_DRAIN;
                        else                   idx_q   <= idx_q + 1'b1;
                    end
                end
                S_DRAIN: state_q <= S_COMMIT;
                S_COMMIT: begin
                    regs_q <= staging_q;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        changed[i] <= (staging_q[i*32 +: 32] != regs_q[i*32 +: 32]);
                    end
                    commit  <= 1'b1;
                    state_q <= S_FLAG;
                end
                default: state_q <= S_FLAG;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_ram_scanner.sv
// Bench for reg_ram_scanner: a granted-access RAM model, a table of sweep vectors with an
// expected-commit scoreboard, plus hand-written idle and mid-sweep reset sequences.
module tb_reg_ram_scanner;

    localparam int           N      = 4;
    localparam logic [127:0] INIT_V = {32'h0000_4004, 32'h0000_3003, 32'h0000_2002, 32'h0000_1001};

    logic           c = 1'b0;
    logic           rst_n = 1'b0;
    logic           ram_gnt = 1'b0;
    logic [7:0]     reg_ram_addr;
    logic           reg_ram_wr;
    logic [31:0]    reg_ram_d;
    logic [31:0]    reg_ram_q = '0;
    logic [127:0]   status_d = '0;
    logic [31:0]    flags;
    logic [127:0]   regs_q;
    logic           commit;
    logic [N-1:0]   changed;

    reg_ram_scanner #(
        .NUM_REGS (N),
        .ADDR_W   (8),
        .BASE_ADDR(0),
        .RO_MASK  (4'b0100),
        .INIT     (INIT_V)
    ) dut (
        .c           (c),
        .rst_n       (rst_n),
        .ram_gnt     (ram_gnt),
        .reg_ram_addr(reg_ram_addr),
        .reg_ram_wr  (reg_ram_wr),
        .reg_ram_d   (reg_ram_d),
        .reg_ram_q   (reg_ram_q),
        .status_d    (status_d),
        .flags       (flags),
        .regs_q      (regs_q),
        .commit      (commit),
        .changed     (changed)
    );

    always #5 c = ~c;

    // Read-first RAM; accepts address and write only with the grant.
    logic [31:0] mem [256];
    always @(posedge c) begin
        if (ram_gnt) begin
            reg_ram_q <= mem[reg_ram_addr];
            if (reg_ram_wr) mem[reg_ram_addr] = reg_ram_d;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    typedef struct packed {
        logic [127:0] ram;       // words for addresses 4..1, slot 2 is overwritten by the DUT
        logic [31:0]  st2;       // status value for RO slot 2
        logic [7:0]   pct;       // grant probability in percent
        logic [127:0] exp_regs;
        logic [3:0]   exp_chg;
    } vec_t;

    typedef struct packed {
        logic [127:0] regs;
        logic [3:0]   chg;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];

    // One sweep: model the grant pattern to predict addresses and commit cycle, then compare.
    task automatic run_vec(input int vi);
        vec_t v;
        bit   g [80];
        int   t, s, n, exp_cc, scan_n, commits, bad, last_commit;
        int   gc [5];
        logic [7:0] ea;
        bit   ea_ok, ew;
        exp_t e;
        v = vecs[vi];
        for (int j = 0; j < 80; j++) g[j] = (j >= 40) ? 1'b1 : ($urandom_range(99) < int'(v.pct));
        t = 0;
        while (!g[t]) t++;
        s = t + 2;
        n = 0;
        for (int j = t + 2; j < 80; j++) begin
            if (g[j]) begin
                n++;
                if (n == 4) begin
                    s = j;
                    break;
                end
            end
        end
        exp_cc = s + 3;
        for (int i = 0; i < 5; i++) gc[i] = 0;
        for (int i = 0; i < N; i++) mem[1 + i] = v.ram[32*i +: 32];
        status_d = {32'hDEAD_0004, v.st2, 32'hDEAD_0002, 32'hDEAD_0001};
        mem[0] = 32'd1;
        sb.push_back('{regs: v.exp_regs, chg: v.exp_chg});
        scan_n = 0;
        commits = 0;
        bad = 0;
        last_commit = -10;
        for (int j = 0; j <= exp_cc + 2; j++) begin
            ram_gnt = g[j];
            if (j == t + 2) begin
                mem[0] = 32'd0;
                check($sformatf("v%0d flags", vi), flags, 128'd1);
            end
            ea_ok = 1'b1;
            ew = 1'b0;
            if (j <= t + 1)       ea = 8'd0;
            else if (j <= s)      ea = 8'(1 + scan_n);
            else if (j == s + 1)  ea = 8'd4;
            else begin
                ea = 8'd0;
                ea_ok = 1'b0;
            end
            if (j >= t + 2 && j <= s) ew = (ea == 8'd3);
            if (ea_ok && reg_ram_addr !== ea) bad++;
            if (reg_ram_wr !== ew) bad++;
            if (reg_ram_d !== (ew ? v.st2 : 32'd0)) bad++;
            if (j >= t + 2 && j <= s && g[j]) begin
                if (reg_ram_addr >= 8'd1 && reg_ram_addr <= 8'd4) gc[reg_ram_addr]++;
                else bad++;
                scan_n++;
            end
            if (commit) begin
                commits++;
                if (last_commit == j - 1) bad++;
                last_commit = j;
                check($sformatf("v%0d latency", vi), 128'(j), 128'(exp_cc));
                if (sb.size() == 0) begin
                    check($sformatf("v%0d unexpected commit", vi), 128'd1, 128'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d regs_q", vi), regs_q, e.regs);
                    check($sformatf("v%0d changed", vi), 128'(changed), 128'(e.chg));
                end
            end
            tick();
        end
        check($sformatf("v%0d commit count", vi), 128'(commits), 128'd1);
        check($sformatf("v%0d addr/wr/d errors", vi), 128'(bad), 128'd0);
        for (int a = 1; a <= 4; a++) check($sformatf("v%0d grants at %0d", vi, a), 128'(gc[a]), 128'd1);
        check($sformatf("v%0d RAM status slot", vi), mem[3], v.st2);
        ram_gnt = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int bad, found;
        vecs[0] = '{128'h44_0000_5555_0000_0022_0000_0011 & {96'h0, 32'h0} | {32'h44, 32'h5555, 32'h22, 32'h11},
                    32'h33, 8'd100, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111};
        vecs[1] = '{{32'h44, 32'h5555, 32'h22, 32'h11}, 32'hCAFE, 8'd100, {32'h44, 32'hCAFE, 32'h22, 32'h11}, 4'b0100};
        vecs[2] = '{{32'h44, 32'h5555, 32'h22, 32'h11}, 32'hCAFE, 8'd50,  {32'h44, 32'hCAFE, 32'h22, 32'h11}, 4'b0000};
        vecs[3] = '{{32'h44, 32'h5555, 32'h99, 32'h11}, 32'hCAFE, 8'd50,  {32'h44, 32'hCAFE, 32'h99, 32'h11}, 4'b0010};
        vecs[4] = '{{32'hC4, 32'h5555, 32'hB2, 32'hA1}, 32'h33,   8'd70,  {32'hC4, 32'h33, 32'hB2, 32'hA1}, 4'b1111};
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) ^ 32'h0BAD_0000;
        mem[0] = 32'd0;

        // Reset state and idle behaviour with the flags word clear.
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset regs_q", regs_q, INIT_V);
        check("reset flags", flags, 128'd0);
        check("reset changed", 128'(changed), 128'd0);
        check("reset commit", 128'(commit), 128'd0);
        check("reset wr", 128'(reg_ram_wr), 128'd0);
        check("reset addr", 128'(reg_ram_addr), 128'd0);
        ram_gnt = 1'b1;
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            if (reg_ram_addr !== 8'd0 || reg_ram_wr !== 1'b0 || commit !== 1'b0) bad++;
            tick();
        end
        check("idle activity", 128'(bad), 128'd0);
        check("idle regs_q", regs_q, INIT_V);
        ram_gnt = 1'b0;
        repeat (3) tick();

        for (int vi = 0; vi < 5; vi++) run_vec(vi);

        // Reset in the middle of a sweep, while register 2 is being addressed.
        mem[0] = 32'd1;
        ram_gnt = 1'b1;
        found = 0;
        for (int j = 0; j < 20 && found == 0; j++) begin
            if (reg_ram_addr == 8'd3) found = 1;
            else tick();
        end
        check("reach idx 2", 128'(found), 128'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async regs_q", regs_q, INIT_V);
        check("async changed", 128'(changed), 128'd0);
        check("async commit", 128'(commit), 128'd0);
        check("async flags", flags, 128'd0);
        check("async wr", 128'(reg_ram_wr), 128'd0);
        check("async addr", 128'(reg_ram_addr), 128'd0);
        mem[0] = 32'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("post-reset addr", 128'(reg_ram_addr), 128'd0);
        bad = 0;
        for (int j = 0; j < 30; j++) begin
            if (commit !== 1'b0) bad++;
            tick();
        end
        check("aborted sweep commits", 128'(bad), 128'd0);
        ram_gnt = 1'b0;
        repeat (3) tick();
        run_vec(0);

        check("scoreboard empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
